// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, drives InstMem's address, and queues fetched
// {pc, instruction} pairs in a 2-entry buffer that decode drains over valid/ready.
module inst_fetch_unit #(
  parameter int unsigned         PC_WIDTH   = 8,
  parameter int unsigned         INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  redirect_en,
  input  logic [PC_WIDTH-1:0]   redirect_target,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]   out_pc
);

  // Buffer occupancy doubles as the state: EMPTY, ONE (1), FULL.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd2;

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [PC_WIDTH-1:0]   ent_pc_q   [2];
  logic [INST_WIDTH-1:0] ent_inst_q [2];

  logic push;
  logic pop;

  assign imem_addr       = pc_q;
  assign out_valid       = (count_q != EMPTY);
  assign out_pc          = ent_pc_q[rd_ptr_q];
  assign out_instruction = ent_inst_q[rd_ptr_q];

  assign pop  = out_valid && out_ready;
  // A full buffer still accepts a fetch when its head leaves on the same edge.
  assign push = fetch_en && !redirect_en && ((count_q != FULL) || pop);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_en) begin
      // Redirect wins: the low two target bits are dropped and the buffer empties.
      pc_d     = redirect_target & ~PC_WIDTH'(3);
      rd_ptr_d = wr_ptr_q;
      count_d  = EMPTY;
    end else begin
      if (push) begin
        pc_d     = pc_q + PC_WIDTH'(4);
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= EMPTY;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry storage is reset because out_pc/out_instruction must read
  // zero during reset; this is only two words, so a reset port costs little.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        ent_pc_q[i]   <= '0;
        ent_inst_q[i] <= '0;
      end
    end else if (push) begin
      ent_pc_q[wr_ptr_q]   <= pc_q;
      ent_inst_q[wr_ptr_q] <= imem_instruction;
    end
  end

endmodule
